// File: rtl/mini_ram_burst_ctrl_if.sv
// Command/stream fabric handshakes plus the single-port RAM port of one
// mini_ram_burst_ctrl; slave is the controller, master is everything around it.
interface mini_ram_burst_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic       rdata_ready;
  logic [7:0] rdata;
  logic       done;
  logic       ram_ce;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata, done, ram_ce, ram_we, ram_addr, ram_din
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, done, ram_ce, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mini_ram_burst_ctrl.sv
// Burst initiator for a mini single-port RAM: write beats pass straight through,
// read beats go through a 2-entry FIFO so downstream backpressure never loses data.
module mini_ram_burst_ctrl #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mini_ram_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           len;
  logic [8:0]           count;
  logic [7:0]           fifo_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_count, fifo_count_next;
  logic                 inflight;
  logic                 done_q, done_next;

  logic       cmd_fire, wr_fire, pop, push, issue, last_beat;
  logic [2:0] occupancy;

  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign wr_fire   = bus.wdata_valid && bus.wdata_ready;
  assign pop       = bus.rdata_valid && bus.rdata_ready;
  assign push      = inflight;
  assign last_beat = (count == {1'b0, len});

  // Slots already claimed (buffered or on their way from the RAM), net of this cycle's pop
  assign occupancy       = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_count_next = fifo_count + {1'b0, push} - {1'b0, pop};

  assign bus.rdata_valid = (fifo_count != 2'd0);
  assign bus.rdata       = fifo_mem[rd_ptr];
  assign bus.done        = done_q;

  always_comb begin
    bus.ram_addr                = '0;
    bus.ram_addr[ADDR_BITS-1:0] = addr;
  end

  always_comb begin
    state_next      = state;
    done_next       = 1'b0;
    issue           = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.ram_ce      = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_din     = '0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = bus.cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        bus.wdata_ready = 1'b1;
        bus.ram_ce      = bus.wdata_valid;
        bus.ram_we      = bus.wdata_valid;
        bus.ram_din     = bus.wdata;
        if (wr_fire && last_beat) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      READ: begin
        issue      = (occupancy < 3'd2);
        bus.ram_ce = issue;
        if (issue && last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_count_next == 2'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      done_q     <= done_next;
      inflight   <= issue;
      fifo_count <= fifo_count_next;
      if (cmd_fire) begin
        addr  <= bus.cmd_addr[ADDR_BITS-1:0];
        len   <= bus.cmd_len;
        count <= '0;
      end else if (wr_fire || issue) begin
        addr  <= addr + 1'b1;
        count <= count + 9'd1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage only; occupancy is tracked by the reset-cleared pointers and count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.ram_dout;
  end

endmodule

// File: tb/tb_mini_ram_burst_ctrl.sv
// Scoreboard bench for mini_ram_burst_ctrl: an 8-bit-address and a 4-bit-address
// instance, each with its own RAM model; sel picks which one the steps exercise.
module tb_mini_ram_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       cmd_valid, cmd_wr, wdata_valid, rdata_ready;
  logic [7:0] cmd_addr, cmd_len, wdata;

  int tests_run = 0;
  int fails     = 0;

  mini_ram_burst_ctrl_if ia();
  mini_ram_burst_ctrl_if ib();

  mini_ram_burst_ctrl #(.ADDR_BITS(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mini_ram_burst_ctrl #(.ADDR_BITS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  assign ia.cmd_valid   = cmd_valid && !sel;
  assign ib.cmd_valid   = cmd_valid && sel;
  assign ia.cmd_wr      = cmd_wr;
  assign ib.cmd_wr      = cmd_wr;
  assign ia.cmd_addr    = cmd_addr;
  assign ib.cmd_addr    = cmd_addr;
  assign ia.cmd_len     = cmd_len;
  assign ib.cmd_len     = cmd_len;
  assign ia.wdata_valid = wdata_valid && !sel;
  assign ib.wdata_valid = wdata_valid && sel;
  assign ia.wdata       = wdata;
  assign ib.wdata       = wdata;
  assign ia.rdata_ready = rdata_ready;
  assign ib.rdata_ready = rdata_ready;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  always @(posedge clk) begin
    if (ia.ram_ce) begin
      if (ia.ram_we) mem_a[ia.ram_addr] <= ia.ram_din;
      else           ia.ram_dout <= mem_a[ia.ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ib.ram_ce) begin
      if (ib.ram_we) mem_b[ib.ram_addr] <= ib.ram_din;
      else           ib.ram_dout <= mem_b[ib.ram_addr];
    end
  end

  logic       m_cmd_ready, m_rvalid, m_done, m_ce, m_we;
  logic [7:0] m_rdata, m_addr, m_din;
  assign m_cmd_ready = sel ? ib.cmd_ready   : ia.cmd_ready;
  assign m_rvalid    = sel ? ib.rdata_valid : ia.rdata_valid;
  assign m_done      = sel ? ib.done        : ia.done;
  assign m_ce        = sel ? ib.ram_ce      : ia.ram_ce;
  assign m_we        = sel ? ib.ram_we      : ia.ram_we;
  assign m_rdata     = sel ? ib.rdata       : ia.rdata;
  assign m_addr      = sel ? ib.ram_addr    : ia.ram_addr;
  assign m_din       = sel ? ib.ram_din     : ia.ram_din;

  // Bench-side picture of what each RAM should hold
  logic [7:0] shadow_a [256];
  logic [7:0] shadow_b [256];

  logic [7:0] exp_waddr[$];
  logic [7:0] exp_wdata[$];
  logic [7:0] exp_raddr[$];
  logic [7:0] exp_rd[$];

  int cyc, done_cnt, outstanding;
  int first_ce_cyc, first_rv_cyc, last_pop_cyc;
  bit held_valid;
  logic [7:0] held_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    bit pop_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        outstanding = 0;
        held_valid  = 0;
        continue;
      end
      pop_now = m_rvalid && rdata_ready;
      if (m_ce && m_we) begin
        if (exp_waddr.size() == 0) checkOutput("wr_unexpected", exp_waddr.size(), 1);
        else begin
          checkOutput("wr_addr", m_addr, exp_waddr.pop_front());
          checkOutput("wr_data", m_din, exp_wdata.pop_front());
        end
      end
      if (m_ce && !m_we) begin
        if (first_ce_cyc < 0) first_ce_cyc = cyc;
        checkOutput("rd_issue_room", (outstanding - int'(pop_now)) < 2, 1);
        if (exp_raddr.size() == 0) checkOutput("rd_unexpected", exp_raddr.size(), 1);
        else checkOutput("rd_addr", m_addr, exp_raddr.pop_front());
        outstanding++;
      end
      if (m_rvalid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (held_valid) checkOutput("rdata_hold", {m_rvalid, m_rdata}, {1'b1, held_data});
      held_valid = m_rvalid && !rdata_ready;
      held_data  = m_rdata;
      if (pop_now) begin
        if (exp_rd.size() == 0) checkOutput("rd_extra_beat", exp_rd.size(), 1);
        else checkOutput("rdata", m_rdata, exp_rd.pop_front());
        last_pop_cyc = cyc;
        outstanding--;
      end
      if (m_done) done_cnt++;
    end
  endtask

  // mode 0: rdata_ready held 1; mode 1: 1010 then 0 for five cycles then 1.
  // base >= 0 writes base+k, otherwise random data. abort_at >= 0 resets after that many pops.
  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] len,
                               input int base, input int mode, input int abort_at);
    logic [7:0] wbeats[$];
    logic [7:0] a, d;
    int mask, j;
    bit got;
    mask = sel ? 'hF : 'hFF;
    for (int k = 0; k <= int'(len); k++) begin
      a = 8'((int'(addr) + k) & mask);
      if (wr) begin
        d = (base >= 0) ? 8'(base + k) : 8'($urandom_range(0, 255));
        wbeats.push_back(d);
        exp_waddr.push_back(a);
        exp_wdata.push_back(d);
        if (sel) shadow_b[a] = d; else shadow_a[a] = d;
      end else begin
        exp_raddr.push_back(a);
        exp_rd.push_back(sel ? shadow_b[a] : shadow_a[a]);
      end
    end
    done_cnt = 0; first_ce_cyc = -1; first_rv_cyc = -1; last_pop_cyc = -1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (m_cmd_ready) got = 1;
    end
    checkOutput("cmd_accept", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (wr) begin
      foreach (wbeats[i]) begin
        wdata_valid = 1'b1;
        wdata       = wbeats[i];
        @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      checkOutput("wr_done_pulse", m_done, 1);
      checkOutput("wr_beats_left", exp_waddr.size(), 0);
    end else begin
      j = 0;
      while (exp_rd.size() != 0 && j < 3000) begin
        if (abort_at >= 0 && (int'(len) + 1 - exp_rd.size()) >= abort_at) break;
        if (mode == 0)  rdata_ready = 1'b1;
        else if (j < 4) rdata_ready = (j % 2 == 0);
        else if (j < 9) rdata_ready = 1'b0;
        else            rdata_ready = 1'b1;
        @(posedge clk); #1;
        j++;
      end
      rdata_ready = 1'b1;
      if (abort_at >= 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rvalid", m_rvalid, 0);
        checkOutput("abort_ram_ce", m_ce, 0);
        checkOutput("abort_cmd_ready", m_cmd_ready, 1);
        exp_rd.delete();
        exp_raddr.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      checkOutput("rd_drained", exp_rd.size(), 0);
      checkOutput("rd_done_pulse", m_done, 1);
      checkOutput("rd_first_latency", first_rv_cyc - first_ce_cyc, 2);
      if (mode == 0) checkOutput("rd_throughput", last_pop_cyc - first_rv_cyc, int'(len));
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_cnt, 1);
    checkOutput("back_to_idle", m_cmd_ready, 1);
  endtask

  initial begin
    cyc = 0; done_cnt = 0; outstanding = 0; held_valid = 0; held_data = '0;
    first_ce_cyc = -1; first_rv_cyc = -1; last_pop_cyc = -1;
    rst_n = 1'b0; sel = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", ia.cmd_ready, 1);
    checkOutput("rst_wdata_ready", ia.wdata_ready, 0);
    checkOutput("rst_rdata_valid", ia.rdata_valid, 0);
    checkOutput("rst_done", ia.done, 0);
    checkOutput("rst_ram_ce", ia.ram_ce, 0);
    checkOutput("rst_ram_we", ia.ram_we, 0);
    checkOutput("rst_ram_addr", ia.ram_addr, 0);
    checkOutput("rst_b_cmd_ready", ib.cmd_ready, 1);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    @(posedge clk); #1;

    $display("[TB] write len=3 at 0x10");
    applyStimulus(1'b1, 8'h10, 8'd3, 'hA0, 0, -1);
    $display("[TB] read back len=3, ready held high");
    applyStimulus(1'b0, 8'h10, 8'd3, -1, 0, -1);
    $display("[TB] read back len=3 with backpressure");
    applyStimulus(1'b0, 8'h10, 8'd3, -1, 1, -1);

    $display("[TB] 4-bit address wrap");
    sel = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h0F, 8'd2, 'h55, 0, -1);
    applyStimulus(1'b0, 8'h0F, 8'd2, -1, 0, -1);
    applyStimulus(1'b0, 8'h0F, 8'd2, -1, 1, -1);
    sel = 1'b0;
    @(posedge clk); #1;

    $display("[TB] full 256-beat bursts");
    applyStimulus(1'b1, 8'h00, 8'd255, -1, 0, -1);
    applyStimulus(1'b0, 8'h80, 8'd255, -1, 0, -1);
    applyStimulus(1'b0, 8'h00, 8'd255, -1, 1, -1);
    applyStimulus(1'b0, 8'hFF, 8'd0, -1, 0, -1);

    $display("[TB] reset in the middle of a read");
    applyStimulus(1'b0, 8'h10, 8'd7, -1, 0, 2);
    applyStimulus(1'b0, 8'h10, 8'd7, -1, 0, -1);
    applyStimulus(1'b1, 8'hFE, 8'd3, -1, 0, -1);
    applyStimulus(1'b0, 8'hFE, 8'd3, -1, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
